// File: rtl/audio_axis_frame_master_if.sv
// audio_axis_frame_master_if: AXI-Stream audio beat bundle.
// master drives data/valid/last, slave drives ready.
interface audio_axis_frame_master_if #(
  parameter int DW = 32
);
  logic [DW-1:0] axis_data;
  logic          axis_valid;
  logic          axis_last;
  logic          axis_ready;

  modport master (
    output axis_data,
    output axis_valid,
    output axis_last,
    input  axis_ready
  );

  modport slave (
    input  axis_data,
    input  axis_valid,
    input  axis_last,
    output axis_ready
  );
endinterface

// File: rtl/audio_axis_frame_master.sv
// audio_axis_frame_master: frame FIFO + AXI-Stream packetiser for audio.
// Optional macro AUDIO_SIGNED_CONV_EN: offset-binary to two's complement.
module audio_axis_frame_master #(
  parameter int NUM_CHANNELS   = 2,
  parameter int AUDIO_IN_DW    = 12,
  parameter int AUDIO_OUT_DW   = 32,
  parameter int AUDIO_BIT_RATE = 24,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic [NUM_CHANNELS*AUDIO_IN_DW-1:0] sample_in,
  input  logic sample_strobe,
  audio_axis_frame_master_if.master axis,
  output logic overflow,
  input  logic overflow_clear,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW =
    (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [CW-1:0] LAST_CH =
    CW'(NUM_CHANNELS - 1);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  typedef logic [AUDIO_OUT_DW-1:0] word_t;

  function automatic word_t fmt(
    input logic [AUDIO_IN_DW-1:0] s
  );
    word_t w;
    logic [AUDIO_IN_DW-1:0] v;
    v = s;
`ifdef AUDIO_SIGNED_CONV_EN
    v[AUDIO_IN_DW-1] = ~s[AUDIO_IN_DW-1];
`endif
    w = '0;
    w[AUDIO_BIT_RATE-1 -: AUDIO_IN_DW] = v;
`ifdef AUDIO_SIGNED_CONV_EN
    for (int i = AUDIO_BIT_RATE; i < AUDIO_OUT_DW; i++)
      w[i] = v[AUDIO_IN_DW-1];
`endif
    return w;
  endfunction

  word_t          mem [FIFO_DEPTH][NUM_CHANNELS];
  word_t          frame [NUM_CHANNELS];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           settled;
  logic           push;
  logic           pop;
  logic           avail;

  state_t         state;
  state_t         state_n;
  logic [CW-1:0]  ch;
  logic [CW-1:0]  ch_n;
  word_t          data_q;
  word_t          data_n;
  logic           valid_q;
  logic           valid_n;
  logic           last_q;
  logic           last_n;

  assign axis.axis_data  = data_q;
  assign axis.axis_valid = valid_q;
  assign axis.axis_last  = last_q;

  assign pop = (state == SEND) && valid_q &&
               axis.axis_ready && (ch == LAST_CH);
  assign push = sample_strobe &&
                ((fifo_level != FULL) || pop);
  // A frame is launched only once it has sat in the FIFO a full cycle.
  assign avail = settled && (fifo_level != '0);

  // Format every channel at capture time.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++)
      frame[c] = fmt(sample_in[c*AUDIO_IN_DW +: AUDIO_IN_DW]);
  end

  // Frame storage; written whole so a frame is captured atomically.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int c = 0; c < NUM_CHANNELS; c++)
        mem[wr_ptr][c] <= frame[c];
    end
  end

  // FIFO pointers, level and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      settled    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        fifo_level <= fifo_level + 1'b1;
      else if (pop && !push)
        fifo_level <= fifo_level - 1'b1;
      settled <= (fifo_level != '0);
      if (sample_strobe && !push)
        overflow <= 1'b1;
      else if (overflow_clear)
        overflow <= 1'b0;
    end
  end

  // FSM state and registered stream outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      ch      <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state   <= state_n;
      ch      <= ch_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      last_q  <= last_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    ch_n    = ch;
    data_n  = data_q;
    valid_n = valid_q;
    last_n  = last_q;
    unique case (state)
      IDLE: begin
        valid_n = 1'b0;
        last_n  = 1'b0;
        if (avail) begin
          data_n  = mem[rd_ptr][0];
          valid_n = 1'b1;
          last_n  = (NUM_CHANNELS == 1);
          ch_n    = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        if (valid_q && axis.axis_ready) begin
          if (ch == LAST_CH) begin
            valid_n = 1'b0;
            last_n  = 1'b0;
            ch_n    = '0;
            state_n = IDLE;
          end else begin
            ch_n   = ch + 1'b1;
            data_n = mem[rd_ptr][ch + 1'b1];
            last_n = ((ch + 1'b1) == LAST_CH);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_audio_axis_frame_master.sv
// tb_audio_axis_frame_master: scoreboard bench, default and 6-channel DUTs.
// Expected words follow AUDIO_SIGNED_CONV_EN when it is defined.
module tb_audio_axis_frame_master;

  logic        clk;
  logic        rst_n;
  logic [23:0] sample_in;
  logic        strobe;
  logic        ovf_clr;
  logic        ovf;
  logic [2:0]  level;
  logic [71:0] sample6;
  logic        strobe6;
  logic        ovf6;
  logic [2:0]  level6;

  int checks;
  int errors;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t sb[$];

  audio_axis_frame_master_if #(.DW(32)) bus ();
  audio_axis_frame_master_if #(.DW(32)) bus6 ();

  audio_axis_frame_master dut (
    .clk            (clk),
    .reset_n        (rst_n),
    .sample_in      (sample_in),
    .sample_strobe  (strobe),
    .axis           (bus),
    .overflow       (ovf),
    .overflow_clear (ovf_clr),
    .fifo_level     (level)
  );

  audio_axis_frame_master #(.NUM_CHANNELS(6)) dut6 (
    .clk            (clk),
    .reset_n        (rst_n),
    .sample_in      (sample6),
    .sample_strobe  (strobe6),
    .axis           (bus6),
    .overflow       (ovf6),
    .overflow_clear (1'b0),
    .fifo_level     (level6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fmt_model(
    input logic [11:0] s
  );
`ifdef AUDIO_SIGNED_CONV_EN
    logic signed [31:0] t;
    t = 32'($signed({~s[11], s[10:0]}));
    return t <<< 12;
`else
    return {8'h00, s, 12'h000};
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted beat of the default DUT is popped and compared.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && bus.axis_valid && bus.axis_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL stray_beat got %h last %b",
                 bus.axis_data, bus.axis_last);
      end else begin
        e = sb.pop_front();
        if ({bus.axis_data, bus.axis_last} !== e) begin
          errors++;
          $display("FAIL beat got %h/%b want %h/%b",
                   bus.axis_data, bus.axis_last, e.d, e.l);
        end
      end
    end
  end

  task automatic send_frame(input logic [23:0] f,
                            input bit keep);
    sample_in = f;
    strobe = 1'b1;
    if (keep) begin
      sb.push_back('{fmt_model(f[11:0]), 1'b0});
      sb.push_back('{fmt_model(f[23:12]), 1'b1});
    end
    tick();
    strobe = 1'b0;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      if (sb.size() == 0 && !bus.axis_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.axis_valid !== 1'b0 || bus.axis_last !== 1'b0) begin
      errors++;
      $display("FAIL rst_vl got %b%b want 00",
               bus.axis_valid, bus.axis_last);
    end
    checks++;
    if (bus.axis_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_data got %h want 0", bus.axis_data);
    end
    checks++;
    if (ovf !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL rst_ovf_lvl got %b/%0d want 0/0", ovf, level);
    end
    checks++;
    if (bus6.axis_valid !== 1'b0 || level6 !== 3'd0) begin
      errors++;
      $display("FAIL rst6 got %b/%0d want 0/0",
               bus6.axis_valid, level6);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    logic [31:0] w0;
`ifdef AUDIO_SIGNED_CONV_EN
    w0 = 32'h002BC000;
`else
    w0 = 32'h00ABC000;
`endif
    bus.axis_ready = 1'b1;
    send_frame({12'h123, 12'hABC}, 1'b1);
    checks++;
    if (bus.axis_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_e0 valid %b want 0", bus.axis_valid);
    end
    tick();
    checks++;
    if (bus.axis_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_e1 valid %b want 0", bus.axis_valid);
    end
    tick();
    checks++;
    if (bus.axis_valid !== 1'b1 || bus.axis_data !== w0 ||
        bus.axis_last !== 1'b0) begin
      errors++;
      $display("FAIL lat_e2 got %b/%h/%b want 1/%h/0",
               bus.axis_valid, bus.axis_data, bus.axis_last, w0);
    end
    drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_drain left %0d want 0", sb.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [23:0] f;
    f = 24'h5A7_0F1;
    bus.axis_ready = 1'b0;
    send_frame(f, 1'b1);
    for (int t = 0; t < 10 && !bus.axis_valid; t++)
      tick();
    bus.axis_ready = 1'b1;
    tick();
    bus.axis_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      checks++;
      if (bus.axis_valid !== 1'b1 || bus.axis_last !== 1'b1 ||
          bus.axis_data !== fmt_model(f[23:12])) begin
        errors++;
        $display("FAIL hold got %b/%h/%b want 1/%h/1",
                 bus.axis_valid, bus.axis_data, bus.axis_last,
                 fmt_model(f[23:12]));
      end
      tick();
    end
    bus.axis_ready = 1'b1;
    drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_drain left %0d want 0", sb.size());
    end
  endtask

  task automatic test_overflow();
    bit ok;
    bus.axis_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send_frame({12'h810 + 12'(i), 12'h200 + 12'(i*7)},
                 (i < 4));
    tick();
    checks++;
    if (level !== 3'd4 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_full got %0d/%b want 4/1", level, ovf);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got %b want 0", ovf);
    end
    bus.axis_ready = 1'b1;
    drain(ok);
    checks++;
    if (!ok || level !== 3'd0) begin
      errors++;
      $display("FAIL ovf_drain left %0d lvl %0d want 0/0",
               sb.size(), level);
    end
  endtask

  task automatic test_full_coincident();
    bit ok;
    bus.axis_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send_frame({12'h0C0 + 12'(i), 12'hF30 - 12'(i)}, 1'b1);
    tick();
    tick();
    tick();
    bus.axis_ready = 1'b1;
    tick();
    send_frame(24'h3E1_7D2, 1'b1);
    checks++;
    if (level !== 3'd4 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL coincide got %0d/%b want 4/0", level, ovf);
    end
    drain(ok);
    checks++;
    if (!ok || level !== 3'd0) begin
      errors++;
      $display("FAIL coin_drain left %0d lvl %0d want 0/0",
               sb.size(), level);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bus.axis_ready = 1'b1;
    send_frame(24'h800_7FF, 1'b1);
    send_frame(24'h3FF_000, 1'b1);
    send_frame(24'hFFF_001, 1'b1);
    drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_drain left %0d want 0", sb.size());
    end
  endtask

  task automatic test_format_const();
    bit ok;
    logic [31:0] w;
`ifdef AUDIO_SIGNED_CONV_EN
    w = 32'hFFBFF000;
`else
    w = 32'h003FF000;
`endif
    bus.axis_ready = 1'b0;
    send_frame(24'h000_3FF, 1'b1);
    for (int t = 0; t < 10 && !bus.axis_valid; t++)
      tick();
    checks++;
    if (bus.axis_data !== w) begin
      errors++;
      $display("FAIL fmt_3ff got %h want %h", bus.axis_data, w);
    end
    bus.axis_ready = 1'b1;
    drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL fmt_drain left %0d want 0", sb.size());
    end
  endtask

  task automatic test_reset_mid_packet();
    int k;
    logic [11:0] ch;
    for (int c = 0; c < 6; c++)
      sample6[c*12 +: 12] = 12'h111 * 12'(c + 1);
    bus6.axis_ready = 1'b0;
    strobe6 = 1'b1;
    tick();
    strobe6 = 1'b0;
    for (int t = 0; t < 10 && !bus6.axis_valid; t++)
      tick();
    bus6.axis_ready = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (bus6.axis_valid !== 1'b1 || bus6.axis_last !== 1'b0 ||
        bus6.axis_data !== fmt_model(12'h444)) begin
      errors++;
      $display("FAIL beat3 got %b/%h/%b want 1/%h/0",
               bus6.axis_valid, bus6.axis_data,
               bus6.axis_last, fmt_model(12'h444));
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus6.axis_valid !== 1'b0 || bus6.axis_last !== 1'b0 ||
        level6 !== 3'd0) begin
      errors++;
      $display("FAIL async_rst got %b/%b/%0d want 0/0/0",
               bus6.axis_valid, bus6.axis_last, level6);
    end
    tick();
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < 6; c++)
      sample6[c*12 +: 12] = 12'hA05 + 12'(c * 19);
    strobe6 = 1'b1;
    tick();
    strobe6 = 1'b0;
    k = 0;
    for (int t = 0; t < 40 && k < 6; t++) begin
      if (bus6.axis_valid) begin
        ch = 12'hA05 + 12'(k * 19);
        checks++;
        if (bus6.axis_data !== fmt_model(ch) ||
            bus6.axis_last !== (k == 5)) begin
          errors++;
          $display("FAIL p6_beat%0d got %h/%b want %h/%b", k,
                   bus6.axis_data, bus6.axis_last,
                   fmt_model(ch), (k == 5));
        end
        k++;
      end
      tick();
    end
    checks++;
    if (k != 6 || bus6.axis_valid !== 1'b0) begin
      errors++;
      $display("FAIL p6_count got %0d beats want 6", k);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    sample_in = '0;
    strobe = 1'b0;
    ovf_clr = 1'b0;
    sample6 = '0;
    strobe6 = 1'b0;
    bus.axis_ready = 1'b0;
    bus6.axis_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_full_coincident();
    test_back_to_back();
    test_format_const();
    test_reset_mid_packet();
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_axis_frame_master.md
Name: audio_axis_frame_master

Overview:
Captures multi-channel audio frames on a sample strobe and queues them in a small frame FIFO. Each frame is emitted as an AXI-Stream packet: one beat per channel, TLAST on the final channel. Replaces the fixed stereo packer between the audio mixer and the I2S/HDMI audio AXIS sink. Adds true valid/ready holding, buffering, overflow reporting, and a configurable channel count.

Parameters:
NUM_CHANNELS, 2, channels per frame (1..8).
AUDIO_IN_DW, 12, input sample width.
AUDIO_OUT_DW, 32, AXIS data width.
AUDIO_BIT_RATE, 24, sample MSB position plus 1. Requires AUDIO_IN_DW <= AUDIO_BIT_RATE <= AUDIO_OUT_DW.
FIFO_DEPTH, 4, frames buffered. Power of 2, >=2.

Ports:
clk  in  1  system clock, all logic on rising edge.
reset_n  in  1  asynchronous active-low reset.
sample_in  in  NUM_CHANNELS*AUDIO_IN_DW  channel c at bits [c*AUDIO_IN_DW +: AUDIO_IN_DW]; channel 0 goes first on the stream.
sample_strobe  in  1  one-cycle pulse; captures sample_in as one frame.
axis_data  out  AUDIO_OUT_DW  stream data (registered).
axis_valid  out  1  stream valid (registered).
axis_last  out  1  high on the last channel beat of a frame.
axis_ready  in  1  sink ready.
overflow  out  1  sticky: a frame was dropped.
overflow_clear  in  1  synchronous clear of overflow.
fifo_level  out  clog2(FIFO_DEPTH)+1  frames currently stored.

Behaviour:
- Clock and reset: one clock (clk). Reset is reset_n, asynchronous, active-low.
- Reset (asynchronous, applies immediately, including mid-packet):
  - axis_data=0, axis_valid=0, axis_last=0, overflow=0, fifo_level=0.
  - FIFO pointers=0, state=IDLE, channel counter=0.
  - A partially sent packet is abandoned; no resume after reset.
- Sample formatting, per channel:
  - word[AUDIO_BIT_RATE-1 : AUDIO_BIT_RATE-AUDIO_IN_DW] = sample.
  - Bits below that field = 0.
  - Bits above AUDIO_BIT_RATE-1 = 0 (legacy mode; see Optional Feature).
  - Formatting happens at capture; the FIFO stores formatted words.
- Push:
  - Occurs when sample_strobe=1 and (fifo_level<FIFO_DEPTH or a pop occurs in the same cycle).
  - Otherwise, a strobe while full drops the incoming frame and sets overflow. The frame already in the FIFO is never overwritten.
- Pop: occurs on the handshake (axis_valid and axis_ready) of the last-channel beat.
- fifo_level updates: +1 on push only, -1 on pop only, unchanged when both occur in the same cycle.
- overflow register:
  - Set has priority over overflow_clear when both occur in the same cycle.
  - Otherwise cleared by overflow_clear.
- FSM, 2 states:
  - IDLE: axis_valid=0. If fifo_level>0, load head channel 0 into axis_data, set axis_valid=1, set axis_last=(NUM_CHANNELS==1), ch=0, go to SEND.
  - SEND: axis_data, axis_valid and axis_last are held stable while axis_ready=0.
    - On handshake with ch<NUM_CHANNELS-1: ch+1, load that channel, set axis_last=(ch+1==NUM_CHANNELS-1).
    - On handshake with ch==NUM_CHANNELS-1: pop, axis_valid=0, axis_last=0, return to IDLE.
- Inter-frame gap: one IDLE bubble cycle minimum between frames. Beats within a frame can be back-to-back.
- Latency: strobe sampled at edge E0 with the FIFO empty and the FSM in IDLE → axis_valid=1 after edge E2.
- Frame integrity: a frame is captured atomically. A strobe arriving while its own frame is being streamed does not alter the words being sent.
- FIFO wrap: pointers are modulo FIFO_DEPTH. fifo_level equals FIFO_DEPTH exactly when full.

Optional Feature:
AUDIO_SIGNED_CONV_EN
- Defined: the input is treated as unsigned offset-binary (Next DAC format).
  - Sample MSB is inverted to produce two's complement.
  - Bits above AUDIO_BIT_RATE-1 are the sign extension of the converted MSB.
- Undefined: samples are copied raw and upper bits are zero-filled (legacy behaviour).

Test Plan:
1. Defaults, macro off. sample_in={12'h123,12'hABC}, strobe, ready=1 → beat 0 = 32'h00ABC000 with last=0; beat 1 = 32'h00123000 with last=1; valid rises 2 edges after strobe.
2. Backpressure: hold ready=0 for 5 cycles mid-packet → data, valid and last unchanged; packet completes correctly after ready=1.
3. ready=0, 5 strobes with distinct data → fifo_level=4, overflow=1, 5th frame absent. Pulse overflow_clear → overflow=0. Drain → frames 1-4 in order.
4. FIFO full, strobe coincident with last-beat handshake → push accepted, fifo_level stays 4, overflow stays 0.
5. Macro on. Channel 0 = 12'hABC → 32'h002BC000. Channel 0 = 12'h3FF → 32'hFFBFF000.
6. NUM_CHANNELS=6: assert reset_n=0 on beat 3 → valid/last drop immediately. After release with one new strobe → full 6-beat packet, last only on beat 5.
